// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [63:0] NOP_PAYLOAD = {NOP_INSTR, 32'h0};

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Upstream and downstream valid/ready handshake bundle for one pipeline stage.
interface pipe_skid_stage_if #(
  parameter int unsigned DATA_W = 64
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Environment side: drives the upstream payload and the downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: main + skid register, registered in_ready,
// synchronous flush to a NOP bubble, saturating stall/flush counters.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W   = 64,
  parameter logic [DATA_W-1:0]  NOP_DATA = DATA_W'(NOP_PAYLOAD),
  parameter int unsigned        CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  pipe_skid_stage_if.slave      bus,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  stage_state_e      r_state;
  stage_state_e      w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              w_accept;
  logic              w_emit;
  logic              w_stall;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_emit   = r_out_valid && bus.out_ready;
  assign w_stall  = r_out_valid && !bus.out_ready && !flush;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = FULL;
          w_main_nxt  = bus.in_data;
        end
      end
      FULL: begin
        if (w_accept && w_emit) begin
          w_main_nxt = bus.in_data;
        end else if (w_accept) begin
          w_state_nxt = SKID;
          w_skid_nxt  = bus.in_data;
        end else if (w_emit) begin
          w_state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (w_emit) begin
          w_state_nxt = FULL;
          w_main_nxt  = r_skid;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush overrides whatever the handshake decided, including a SKID drain.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = NOP_DATA;
      w_skid_nxt  = NOP_DATA;
    end
  end

  // Handshake flags are registered copies of the next state, so in_ready
  // never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main      <= NOP_DATA;
      r_skid      <= NOP_DATA;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= (w_state_nxt != SKID);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule
